// File: rtl/axil_cfg_responder.sv
// AXI4-Lite slave bridging single transactions onto a strobe-based config register bus.
// One transaction in flight; writes win over reads; reads time out with SLVERR.
module axil_cfg_responder #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32,
  parameter int RD_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] axi4_slave_awaddr,
  input  logic                  axi4_slave_awvalid,
  output logic                  axi4_slave_awready,
  input  logic [DATA_WIDTH-1:0] axi4_slave_wdata,
  input  logic                  axi4_slave_wvalid,
  output logic                  axi4_slave_wready,
  output logic [1:0]            axi4_slave_bresp,
  output logic                  axi4_slave_bvalid,
  input  logic                  axi4_slave_bready,
  input  logic [ADDR_WIDTH-1:0] axi4_slave_araddr,
  input  logic                  axi4_slave_arvalid,
  output logic                  axi4_slave_arready,
  output logic [DATA_WIDTH-1:0] axi4_slave_rdata,
  output logic [1:0]            axi4_slave_rresp,
  output logic                  axi4_slave_rvalid,
  input  logic                  axi4_slave_rready,
  output logic                  cfg_wr_en,
  output logic                  cfg_rd_en,
  output logic [ADDR_WIDTH-1:0] cfg_addr,
  output logic [DATA_WIDTH-1:0] cfg_wr_data,
  input  logic [DATA_WIDTH-1:0] cfg_rd_data,
  input  logic                  cfg_rd_data_valid
);
  typedef enum logic [2:0] {IDLE, WR_ISSUE, WR_RESP, RD_ISSUE, RD_WAIT, RD_RESP} state_e;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [7:0] TMO_LAST = 8'(RD_TIMEOUT - 1);

  state_e                state_q, state_d;
  logic                  aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [1:0]            bresp_q, bresp_d, rresp_q, rresp_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  idle, aw_hs, w_hs, ar_hs, wr_ok, rd_ok, tmo;

  assign idle  = (state_q == IDLE);
  assign wr_ok = (awaddr_q[1:0] == 2'b00);
  assign rd_ok = (araddr_q[1:0] == 2'b00);
  assign tmo   = (cnt_q == TMO_LAST);

  // Readies are gated by reset so every output reads 0 while reset is held.
  assign axi4_slave_awready = reset && idle && !aw_held_q;
  assign axi4_slave_wready  = reset && idle && !w_held_q;
  assign axi4_slave_arready = reset && idle && !aw_held_q && !w_held_q
                              && !axi4_slave_awvalid && !axi4_slave_wvalid;

  assign aw_hs = axi4_slave_awvalid && axi4_slave_awready;
  assign w_hs  = axi4_slave_wvalid  && axi4_slave_wready;
  assign ar_hs = axi4_slave_arvalid && axi4_slave_arready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      araddr_q  <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      bresp_q   <= OKAY;
      rresp_q   <= OKAY;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awaddr_q  <= awaddr_d;
      araddr_q  <= araddr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      bresp_q   <= bresp_d;
      rresp_q   <= rresp_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if ((aw_held_q || aw_hs) && (w_held_q || w_hs)) state_d = WR_ISSUE;
        else if (ar_hs)                                 state_d = RD_ISSUE;
      end
      WR_ISSUE: state_d = WR_RESP;
      WR_RESP:  if (axi4_slave_bready) state_d = IDLE;
      RD_ISSUE: state_d = rd_ok ? RD_WAIT : RD_RESP;
      RD_WAIT:  if (cfg_rd_data_valid || tmo) state_d = RD_RESP;
      RD_RESP:  if (axi4_slave_rready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    araddr_d  = araddr_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    bresp_d   = bresp_q;
    cnt_d     = cnt_q;
    if (aw_hs) begin aw_held_d = 1'b1; awaddr_d = axi4_slave_awaddr; end
    if (w_hs)  begin w_held_d  = 1'b1; wdata_d  = axi4_slave_wdata;  end
    if (ar_hs) araddr_d = axi4_slave_araddr;
    case (state_q)
      WR_ISSUE: begin
        aw_held_d = 1'b0;
        w_held_d  = 1'b0;
        bresp_d   = wr_ok ? OKAY : SLVERR;
      end
      RD_ISSUE: begin
        cnt_d = '0;
        if (!rd_ok) begin rdata_d = '0; rresp_d = SLVERR; end
      end
      RD_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        // Data arriving on the timeout cycle still counts as a good read.
        if (cfg_rd_data_valid) begin rdata_d = cfg_rd_data; rresp_d = OKAY; end
        else if (tmo)          begin rdata_d = '0;          rresp_d = SLVERR; end
      end
      default: ;
    endcase
  end

  always_comb begin
    cfg_wr_en         = 1'b0;
    cfg_rd_en         = 1'b0;
    cfg_addr          = '0;
    cfg_wr_data       = '0;
    axi4_slave_bvalid = 1'b0;
    axi4_slave_rvalid = 1'b0;
    case (state_q)
      WR_ISSUE: if (wr_ok) begin
        cfg_wr_en   = 1'b1;
        cfg_addr    = awaddr_q;
        cfg_wr_data = wdata_q;
      end
      WR_RESP:  axi4_slave_bvalid = 1'b1;
      RD_ISSUE: if (rd_ok) begin
        cfg_rd_en = 1'b1;
        cfg_addr  = araddr_q;
      end
      RD_RESP:  axi4_slave_rvalid = 1'b1;
      default: ;
    endcase
  end

  assign axi4_slave_bresp = bresp_q;
  assign axi4_slave_rdata = rdata_q;
  assign axi4_slave_rresp = rresp_q;
endmodule

// File: tb/tb_axil_cfg_responder.sv
// Scoreboard bench for axil_cfg_responder: main instance (default timeout) plus a
// short-timeout instance used for the SLVERR-on-timeout path.
module tb_axil_cfg_responder;
  logic clk = 1'b0, reset = 1'b0;
  always #5 clk = ~clk;

  logic [12:0] awaddr = '0, araddr = '0, cfg_addr;
  logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0, cfg_rd_data_valid = 0;
  logic [31:0] wdata = '0, rdata, cfg_wr_data, cfg_rd_data = '0;
  logic        awready, wready, bvalid, arready, rvalid, cfg_wr_en, cfg_rd_en;
  logic [1:0]  bresp, rresp;

  axil_cfg_responder u_dut (
    .clk(clk), .reset(reset),
    .axi4_slave_awaddr(awaddr), .axi4_slave_awvalid(awvalid), .axi4_slave_awready(awready),
    .axi4_slave_wdata(wdata), .axi4_slave_wvalid(wvalid), .axi4_slave_wready(wready),
    .axi4_slave_bresp(bresp), .axi4_slave_bvalid(bvalid), .axi4_slave_bready(bready),
    .axi4_slave_araddr(araddr), .axi4_slave_arvalid(arvalid), .axi4_slave_arready(arready),
    .axi4_slave_rdata(rdata), .axi4_slave_rresp(rresp), .axi4_slave_rvalid(rvalid),
    .axi4_slave_rready(rready),
    .cfg_wr_en(cfg_wr_en), .cfg_rd_en(cfg_rd_en), .cfg_addr(cfg_addr), .cfg_wr_data(cfg_wr_data),
    .cfg_rd_data(cfg_rd_data), .cfg_rd_data_valid(cfg_rd_data_valid)
  );

  // short-timeout instance: only the read channel is exercised
  logic [12:0] t_awaddr = '0, t_araddr = '0, t_cfg_addr;
  logic        t_awvalid = 0, t_wvalid = 0, t_bready = 0, t_arvalid = 0, t_rready = 0, t_cfg_rd_data_valid = 0;
  logic [31:0] t_wdata = '0, t_rdata, t_cfg_wr_data, t_cfg_rd_data = '0;
  logic        t_awready, t_wready, t_bvalid, t_arready, t_rvalid, t_cfg_wr_en, t_cfg_rd_en;
  logic [1:0]  t_bresp, t_rresp;

  axil_cfg_responder #(.RD_TIMEOUT(4)) u_tmo (
    .clk(clk), .reset(reset),
    .axi4_slave_awaddr(t_awaddr), .axi4_slave_awvalid(t_awvalid), .axi4_slave_awready(t_awready),
    .axi4_slave_wdata(t_wdata), .axi4_slave_wvalid(t_wvalid), .axi4_slave_wready(t_wready),
    .axi4_slave_bresp(t_bresp), .axi4_slave_bvalid(t_bvalid), .axi4_slave_bready(t_bready),
    .axi4_slave_araddr(t_araddr), .axi4_slave_arvalid(t_arvalid), .axi4_slave_arready(t_arready),
    .axi4_slave_rdata(t_rdata), .axi4_slave_rresp(t_rresp), .axi4_slave_rvalid(t_rvalid),
    .axi4_slave_rready(t_rready),
    .cfg_wr_en(t_cfg_wr_en), .cfg_rd_en(t_cfg_rd_en), .cfg_addr(t_cfg_addr), .cfg_wr_data(t_cfg_wr_data),
    .cfg_rd_data(t_cfg_rd_data), .cfg_rd_data_valid(t_cfg_rd_data_valid)
  );

  int n_chk = 0, n_err = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct packed { logic [12:0] a; logic [31:0] d; } wr_t;
  wr_t         exp_wr[$];
  logic [12:0] exp_rd[$];
  logic [1:0]  exp_b[$];
  logic [33:0] exp_r[$];
  wr_t         ew;
  logic [33:0] er;
  int cyc = 0, b_cyc = 0, last_ar_cyc = 0;
  int rd_lat = 0;
  logic [31:0] rd_val = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // monitor: pops expectations as the DUT produces strobes / responses
  always @(negedge clk) begin
    if (cfg_wr_en) begin
      if (exp_wr.size() == 0) chk("wr_unexpected", 1, 0);
      else begin
        ew = exp_wr.pop_front();
        chk("wr_addr", cfg_addr, ew.a);
        chk("wr_data", cfg_wr_data, ew.d);
      end
    end
    if (cfg_rd_en) begin
      if (exp_rd.size() == 0) chk("rd_unexpected", 1, 0);
      else chk("rd_addr", cfg_addr, exp_rd.pop_front());
    end
    if (!cfg_wr_en && !cfg_rd_en) chk("cfg_addr_idle", cfg_addr, 0);
    if (bvalid && bready) begin
      b_cyc = cyc;
      if (exp_b.size() == 0) chk("b_unexpected", 1, 0);
      else chk("bresp", bresp, exp_b.pop_front());
    end
    if (rvalid && rready) begin
      if (exp_r.size() == 0) chk("r_unexpected", 1, 0);
      else begin
        er = exp_r.pop_front();
        chk("rdata", rdata, er[33:2]);
        chk("rresp", rresp, er[1:0]);
      end
    end
  end

  // register-file model: answers rd_lat cycles after cfg_rd_en (0 = never)
  initial forever begin
    @(negedge clk);
    if (cfg_rd_en && rd_lat != 0) begin
      repeat (rd_lat) @(posedge clk);
      #1 cfg_rd_data = rd_val; cfg_rd_data_valid = 1;
      @(posedge clk);
      #1 cfg_rd_data_valid = 0;
    end
  end

  task automatic wr_txn(input logic [12:0] a, input logic [31:0] d, input int w_lead, input int b_stall);
    int n;
    logic ok, aw_hs, w_hs, w_done;
    logic [1:0] eb;
    wr_t e;
    ok = (a[1:0] == 2'b00);
    eb = ok ? 2'b00 : 2'b10;
    e.a = a; e.d = d;
    if (ok) exp_wr.push_back(e);
    exp_b.push_back(eb);
    wdata = d; wvalid = 1; w_done = 0;
    if (w_lead > 0) begin
      @(negedge clk); chk("w_ready", wready, 1);
      @(posedge clk); #1 wvalid = 0; w_done = 1;
      for (int i = 0; i < w_lead; i++) begin
        @(negedge clk); chk("w_ready_drop", wready, 0);
        if (i < w_lead - 1) begin @(posedge clk); #1; end
      end
      @(posedge clk); #1;
    end
    awaddr = a; awvalid = 1; n = 0;
    while ((awvalid || wvalid) && n < 50) begin
      @(negedge clk); n++;
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(posedge clk); #1;
      if (aw_hs) awvalid = 0;
      if (w_hs)  wvalid = 0;
    end
    chk("aw_w_accept", {awvalid, wvalid, w_done && w_hs}, 0);
    @(negedge clk); chk("wr_strobe_lat", cfg_wr_en, ok);
    @(posedge clk); #1 bready = (b_stall == 0);
    @(negedge clk); chk("b_lat", bvalid, 1);
    for (int i = 0; i < b_stall; i++) begin
      chk("b_hold_valid", bvalid, 1);
      chk("b_hold_resp", bresp, eb);
      @(posedge clk); #1;
      if (i == b_stall - 1) bready = 1;
      @(negedge clk);
    end
    @(posedge clk); #1 bready = 0;
  endtask

  task automatic rd_txn(input logic [12:0] a, input logic [31:0] d, input int lat);
    int n;
    logic ok;
    ok = (a[1:0] == 2'b00);
    rd_lat = ok ? lat : 0; rd_val = d;
    if (ok) exp_rd.push_back(a);
    exp_r.push_back(ok ? {d, 2'b00} : {32'h0, 2'b10});
    araddr = a; arvalid = 1; n = 0;
    do begin @(negedge clk); n++; end while (!arready && n < 40);
    chk("ar_accept", arready, 1);
    last_ar_cyc = cyc;
    @(posedge clk); #1 arvalid = 0; n = 0;
    do begin @(negedge clk); n++; end while (!rvalid && n < 300);
    chk("r_lat", n, ok ? lat + 2 : 2);
    @(posedge clk); #1 rready = 1;
    @(negedge clk); chk("r_hold", rvalid, 1);
    @(posedge clk); #1 rready = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctl", {awready, wready, arready, bvalid, bresp, rvalid, rresp, cfg_wr_en, cfg_rd_en}, 0);
    chk("rst_dat", {rdata, cfg_addr}, 0);
    chk("rst_wdat", cfg_wr_data, 0);
    reset = 1;
    @(negedge clk); chk("post_rst_ready", {awready, wready, arready}, 3'b111);
    @(posedge clk); #1;

    wr_txn(13'h010, 32'hDEADBEEF, 0, 0);
    wr_txn(13'h024, 32'hCAFEF00D, 3, 4);
    rd_txn(13'h020, 32'h12345678, 5);

    // timeout on the RD_TIMEOUT=4 instance
    t_araddr = 13'h040; t_arvalid = 1;
    @(negedge clk); chk("t_ar_ready", t_arready, 1);
    @(posedge clk); #1 t_arvalid = 0; n = 0;
    do begin @(negedge clk); n++; end while (!t_rvalid && n < 20);
    chk("t_tmo_lat", n, 6);
    chk("t_tmo_rdata", t_rdata, 0);
    chk("t_tmo_rresp", t_rresp, 2'b10);
    @(posedge clk); #1 t_rready = 1;
    @(posedge clk); #1 t_rready = 0;
    t_cfg_rd_data = 32'hBAD0BAD0; t_cfg_rd_data_valid = 1;
    @(posedge clk); #1 t_cfg_rd_data_valid = 0;
    @(negedge clk); chk("t_late_ignored", t_rvalid, 0);
    @(posedge clk); #1 t_araddr = 13'h044; t_arvalid = 1;
    @(negedge clk); chk("t_ar_ready2", t_arready, 1);
    @(posedge clk); #1 t_arvalid = 0;
    @(negedge clk); chk("t_rd_strobe", t_cfg_rd_en, 1);
    @(posedge clk); #1;
    @(posedge clk); #1 t_cfg_rd_data = 32'h0F0F1234; t_cfg_rd_data_valid = 1;
    @(posedge clk); #1 t_cfg_rd_data_valid = 0;
    @(negedge clk);
    chk("t_rvalid2", t_rvalid, 1);
    chk("t_rdata2", t_rdata, 32'h0F0F1234);
    chk("t_rresp2", t_rresp, 2'b00);
    @(posedge clk); #1 t_rready = 1;
    @(posedge clk); #1 t_rready = 0;

    // write and read presented together: read waits for the B handshake
    fork
      wr_txn(13'h030, 32'h0BADF00D, 0, 0);
      rd_txn(13'h034, 32'h55AA55AA, 2);
    join
    chk("ar_after_b", last_ar_cyc, b_cyc + 1);

    wr_txn(13'h013, 32'h11111111, 0, 0);
    rd_txn(13'h022, 32'h22222222, 3);

    // reset while waiting for read data
    rd_lat = 0; exp_rd.push_back(13'h050);
    araddr = 13'h050; arvalid = 1;
    @(negedge clk); chk("rst_ar_ready", arready, 1);
    @(posedge clk); #1 arvalid = 0;
    repeat (3) @(posedge clk);
    #2 reset = 0;
    #1;
    chk("mid_rst_ctl", {awready, wready, arready, bvalid, bresp, rvalid, rresp, cfg_wr_en, cfg_rd_en}, 0);
    chk("mid_rst_dat", {rdata, cfg_addr}, 0);
    @(posedge clk); #1 reset = 1;
    @(negedge clk); chk("mid_rst_idle", {awready, wready, arready, rvalid}, 4'b1110);
    repeat (8) @(negedge clk);
    chk("mid_rst_no_resp", {rvalid, bvalid}, 0);
    @(posedge clk); #1;
    rd_txn(13'h008, 32'h0000ABCD, 1);

    chk("queues_empty", exp_wr.size() + exp_rd.size() + exp_b.size() + exp_r.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/axil_cfg_responder.md
# axil_cfg_responder

AXI4-Lite slave that terminates the CGRA control port and converts each AXI-Lite transaction into a single-beat access on a simple configuration register bus. It sits between the processor-side AXI4-Lite interface (CGRA_AXI_ADDR_WIDTH / CGRA_AXI_DATA_WIDTH) and the global controller's register file. Writes accept AW and W in either order. Reads tolerate variable register-file latency and return SLVERR on timeout. One transaction is in flight at a time, and writes have priority over reads.

## Interface
- ADDR_WIDTH, 13, AXI and cfg address width (byte address)
- DATA_WIDTH, 32, AXI and cfg data width
- RD_TIMEOUT, 255, max RD_WAIT cycles before SLVERR (1..255, 8-bit counter)

- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-low; 0 = reset asserted
- axi4_slave_awaddr/awvalid/awready  in/in/out  ADDR_WIDTH/1/1  write address channel
- axi4_slave_wdata/wvalid/wready  in/in/out  DATA_WIDTH/1/1  write data channel
- axi4_slave_bresp/bvalid/bready  out/out/in  2/1/1  write response channel
- axi4_slave_araddr/arvalid/arready  in/in/out  ADDR_WIDTH/1/1  read address channel
- axi4_slave_rdata/rresp/rvalid/rready  out/out/out/in  DATA_WIDTH/2/1/1  read data channel
- cfg_wr_en  out  1  one-cycle write strobe
- cfg_rd_en  out  1  one-cycle read strobe
- cfg_addr  out  ADDR_WIDTH  access address, valid with either strobe
- cfg_wr_data  out  DATA_WIDTH  write data, valid with cfg_wr_en
- cfg_rd_data  in  DATA_WIDTH  read data, sampled with cfg_rd_data_valid
- cfg_rd_data_valid  in  1  read data valid pulse

## Operation
- State machine states: IDLE, WR_ISSUE, WR_RESP, RD_ISSUE, RD_WAIT, RD_RESP.
- AW holding register:
  - Plus flag aw_held. awready = !aw_held && state ∈ {IDLE}.
  - Handshake (awvalid && awready) latches awaddr and sets aw_held.
- W holding register:
  - Same structure as AW, with flag w_held.
  - wready = !w_held && state == IDLE.
- IDLE → WR_ISSUE:
  - Taken when both AW and W are held, or are completing handshake this cycle.
  - The cycle after, the block is in WR_ISSUE.
- WR_ISSUE:
  - If awaddr[1:0] == 0: cfg_wr_en=1, cfg_addr=awaddr, cfg_wr_data=wdata, bresp=OKAY(2'b00).
  - Else (misaligned): no strobe, bresp=SLVERR(2'b10).
  - Clear aw_held and w_held. Go to WR_RESP.
- WR_RESP: bvalid=1, held stable until bready. On handshake → IDLE.
- arready = state==IDLE && !aw_held && !w_held && !awvalid && !wvalid.
  - Any pending or presented write blocks reads, so writes have priority.
  - arready depends combinationally on awvalid/wvalid; this is legal AXI.
- AR handshake: latch araddr, → RD_ISSUE.
- RD_ISSUE:
  - If araddr[1:0]==0: cfg_rd_en=1, cfg_addr=araddr, clear timeout counter, → RD_WAIT.
  - Else: rresp=SLVERR, rdata=0, → RD_RESP directly.
- RD_WAIT: counter increments each cycle.
  - cfg_rd_data_valid=1: capture cfg_rd_data, rresp=OKAY, → RD_RESP.
  - Else if counter == RD_TIMEOUT-1: rdata=0, rresp=SLVERR, → RD_RESP.
  - If valid arrives on the timeout cycle, valid wins.
- RD_RESP: rvalid=1, rdata/rresp held stable until rready. On handshake → IDLE.
- cfg_rd_data_valid is ignored in every state except RD_WAIT. Late data after a timeout is discarded.
- Write strobe data is 32-bit full word; no byte strobes.
- cfg_addr = 0 when no strobe is active.

## Timing
- Reset values (asynchronous, while reset==0): state=IDLE, aw_held=w_held=0, all outputs 0.
  - Outputs covered: awready, wready, arready, bvalid, bresp, rvalid, rresp, rdata, cfg_*.
  - Ready signals go 1 in the first cycle after reset deasserts, since they are combinational from IDLE.
- Write latency: last of AW/W handshake at cycle N → cfg_wr_en at N+1 → bvalid at N+2.
- Read latency: AR handshake at N → cfg_rd_en at N+1 → RD_WAIT from N+2.
  - cfg_rd_data_valid at cycle K (K ≥ N+2) → rvalid at K+1.
  - Timeout response: rvalid at N+2+RD_TIMEOUT.
- bvalid/rvalid stay high with unchanged payload across any number of not-ready cycles.
- Reset mid-transaction:
  - Any held AW/W and any in-flight read are dropped.
  - No response is issued.
  - No strobe is issued after reset.

## Test plan
- Write, AW and W in same cycle:
  - Stimulus: awaddr=0x010, wdata=0xDEADBEEF.
  - Required: cfg_wr_en one cycle later with cfg_addr=0x010, cfg_wr_data=0xDEADBEEF; bvalid next cycle with bresp=0.
- W 3 cycles before AW:
  - Required: wready drops after the W handshake; single cfg_wr_en after AW; bready held low 4 cycles keeps bvalid=1 and bresp stable.
- Read, responder latency 5:
  - Stimulus: araddr=0x020, responder returns 0x12345678 five cycles after cfg_rd_en.
  - Required: rvalid with rdata=0x12345678, rresp=0.
- Read timeout:
  - Stimulus: RD_TIMEOUT=4, no cfg_rd_data_valid.
  - Required: rvalid at AR+6 with rdata=0, rresp=2; a cfg_rd_data_valid pulse afterward does not disturb the next read.
- Simultaneous awvalid, wvalid, arvalid in IDLE:
  - Required: arready=0 until the write completes (bready handshake); the read is then accepted and served.
- Misaligned addresses and reset:
  - Misaligned awaddr=0x013 / araddr=0x022: no cfg strobes; bresp=2 / rresp=2.
  - Reset asserted during RD_WAIT: all outputs 0 immediately, IDLE after release.
